// File: rtl/dyn_mem_pkg.sv
// Shared types for the dynamic-latency memory: FSM state encoding.
package dyn_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_RD = 2'b01,
    ST_BUSY_WR = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

endpackage

// File: rtl/dyn_latency_mem_d1_if.sv
// Request/response bus of dyn_latency_mem_d1; addr_err exists only with DYN_MEM_ADDR_CHECK_EN.
interface dyn_latency_mem_d1_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic [IDX_SIZE-1:0] addr0;
  logic                read_en;
  logic                write_en;
  logic [WIDTH-1:0]    write_data;
  logic [WIDTH-1:0]    read_data;
  logic                read_done;
  logic                write_done;
`ifdef DYN_MEM_ADDR_CHECK_EN
  logic                addr_err;

  modport master (
    output addr0, read_en, write_en, write_data,
    input  read_data, read_done, write_done, addr_err
  );
  modport slave (
    input  addr0, read_en, write_en, write_data,
    output read_data, read_done, write_done, addr_err
  );
`else
  modport master (
    output addr0, read_en, write_en, write_data,
    input  read_data, read_done, write_done
  );
  modport slave (
    input  addr0, read_en, write_en, write_data,
    output read_data, read_done, write_done
  );
`endif
endinterface

// File: rtl/dyn_mem_lat_counter.sv
// Latency down-counter: load sets LATENCY-1, dec counts toward zero and saturates there.
module dyn_mem_lat_counter #(
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/dyn_latency_mem_d1.sv
// Word memory with fixed programmable access latency and level request / pulse completion.
// Optional out-of-range reporting on addr_err when DYN_MEM_ADDR_CHECK_EN is defined.
module dyn_latency_mem_d1
  import dyn_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4,
  parameter int LATENCY  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  dyn_latency_mem_d1_if.slave  bus
);
  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("dyn_latency_mem_d1: LATENCY must be at least 1");
    end
  endgenerate

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [31:0] SIZE_W = 32'(SIZE);

  state_e              state_q, state_d;
  logic [IDX_SIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    read_data_q, read_data_d;
  logic                read_done_q, read_done_d;
  logic                write_done_q, write_done_d;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic                mem_we;
  logic                in_range;
  logic [AW-1:0]       idx;
  logic [WIDTH-1:0]    mem_q [SIZE];
`ifdef DYN_MEM_ADDR_CHECK_EN
  logic                addr_err_q, addr_err_d;
`endif

  dyn_mem_lat_counter #(.LATENCY(LATENCY)) u_lat_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  assign in_range = (32'(addr_q) < SIZE_W);
  assign idx      = AW'(addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.read_en) begin
          state_d = ST_BUSY_RD;
        end else if (bus.write_en) begin
          state_d = ST_BUSY_WR;
        end
      end
      ST_BUSY_RD, ST_BUSY_WR: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Done flags default low, so the DONE state clears them without extra logic.
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_data_d  = read_data_q;
    read_done_d  = 1'b0;
    write_done_d = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    mem_we       = 1'b0;
`ifdef DYN_MEM_ADDR_CHECK_EN
    addr_err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.read_en) begin
          addr_d   = bus.addr0;
          cnt_load = 1'b1;
        end else if (bus.write_en) begin
          addr_d   = bus.addr0;
          wdata_d  = bus.write_data;
          cnt_load = 1'b1;
        end
      end
      ST_BUSY_RD: begin
        if (cnt_zero) begin
          read_data_d = in_range ? mem_q[idx] : '0;
          read_done_d = 1'b1;
`ifdef DYN_MEM_ADDR_CHECK_EN
          addr_err_d  = ~in_range;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_BUSY_WR: begin
        if (cnt_zero) begin
          mem_we       = in_range;
          write_done_d = 1'b1;
`ifdef DYN_MEM_ADDR_CHECK_EN
          addr_err_d   = ~in_range;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      read_data_q  <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
`ifdef DYN_MEM_ADDR_CHECK_EN
      addr_err_q   <= 1'b0;
`endif
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_data_q  <= read_data_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
`ifdef DYN_MEM_ADDR_CHECK_EN
      addr_err_q   <= addr_err_d;
`endif
    end
  end

  // Memory is not reset; a reset in the write cycle still suppresses the update.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_done  = read_done_q;
  assign bus.write_done = write_done_q;
`ifdef DYN_MEM_ADDR_CHECK_EN
  assign bus.addr_err   = addr_err_q;
`endif
endmodule

// File: tb/tb_dyn_latency_mem_d1.sv
// Scoreboard bench for dyn_latency_mem_d1: directed scenarios then randomized traffic.
module tb_dyn_latency_mem_d1;
  localparam int WIDTH    = 32;
  localparam int SIZE     = 16;
  localparam int IDX_SIZE = 5;
  localparam int LATENCY  = 3;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          oor;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [SIZE];
  logic [31:0] hold = '0;
  int          cyc = 0;
  int          next_free = 0;
  int          total = 0;
  int          bad = 0;
  bit          started = 1'b0;

  dyn_latency_mem_d1_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus ();

  dyn_latency_mem_d1 #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .IDX_SIZE (IDX_SIZE),
    .LATENCY  (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h, want %h (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: accepted at edge acc, completes at acc+LATENCY, idle again two edges later.
  task automatic push_exp(input bit rd, input logic [IDX_SIZE-1:0] a, input logic [31:0] d, input int acc);
    exp_t e;
    bit   inr;
    inr       = (int'(a) < SIZE);
    e.is_read = rd;
    e.oor     = !inr;
    e.cyc     = acc + LATENCY;
    e.data    = '0;
    if (rd) begin
      if (inr) e.data = ref_mem[int'(a)];
    end else if (inr) begin
      ref_mem[int'(a)] = d;
    end
    sb.push_back(e);
    next_free = acc + LATENCY + 2;
  endtask

  // mode 0: hold until done; 1: drop enables after acceptance; 2: hold through DONE (re-accepted)
  task automatic op(input bit rd, input bit wr, input logic [IDX_SIZE-1:0] a, input logic [31:0] d, input int mode);
    int acc;
    while (cyc + 1 < next_free) step();
    bus.read_en    = rd;
    bus.write_en   = wr;
    bus.addr0      = a;
    bus.write_data = d;
    acc = cyc + 1;
    push_exp(rd, a, d, acc);
    step();
    if (mode == 1) begin
      bus.read_en  = 1'b0;
      bus.write_en = 1'b0;
    end
    if (mode != 2) begin
      bus.addr0      = IDX_SIZE'($urandom);
      bus.write_data = $urandom;
    end
    while (cyc < acc + LATENCY) step();
    if (mode == 2) begin
      step();
      push_exp(rd, a, d, acc + LATENCY + 2);
      acc = acc + LATENCY + 2;
      step();
      bus.addr0      = IDX_SIZE'($urandom);
      bus.write_data = $urandom;
      while (cyc < acc + LATENCY) step();
    end
    bus.read_en  = 1'b0;
    bus.write_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (bus.read_done || bus.write_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got rd=%0b wr=%0b, want no completion (edge %0d)",
                   bus.read_done, bus.write_done, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk((bus.read_done == mon_e.is_read) && (bus.write_done == !mon_e.is_read), "done_kind",
              {30'b0, bus.read_done, bus.write_done}, {30'b0, mon_e.is_read, !mon_e.is_read});
          chk(cyc == mon_e.cyc, "done_edge", cyc, mon_e.cyc);
          if (mon_e.is_read) begin
            chk(bus.read_data == mon_e.data, "read_data", bus.read_data, mon_e.data);
            hold = mon_e.data;
          end else begin
            chk(bus.read_data == hold, "rd_hold_on_write", bus.read_data, hold);
          end
`ifdef DYN_MEM_ADDR_CHECK_EN
          chk(bus.addr_err == mon_e.oor, "addr_err", {31'b0, bus.addr_err}, {31'b0, mon_e.oor});
`endif
        end
      end else begin
        chk(bus.read_data == hold, "rd_hold", bus.read_data, hold);
`ifdef DYN_MEM_ADDR_CHECK_EN
        chk(bus.addr_err == 1'b0, "addr_err_idle", {31'b0, bus.addr_err}, 32'h0);
`endif
      end
      if (rst) hold = '0;
    end
  end

  initial begin
    bus.read_en    = 1'b0;
    bus.write_en   = 1'b0;
    bus.addr0      = '0;
    bus.write_data = '0;
    rst = 1'b1;
    repeat (3) step();
    chk(bus.read_data == '0, "reset_read_data", bus.read_data, 32'h0);
    chk(bus.read_done == 1'b0, "reset_read_done", {31'b0, bus.read_done}, 32'h0);
    chk(bus.write_done == 1'b0, "reset_write_done", {31'b0, bus.write_done}, 32'h0);
    rst = 1'b0;
    next_free = cyc + 1;
    started = 1'b1;

    for (int i = 0; i < SIZE; i++) op(1'b0, 1'b1, IDX_SIZE'(i), $urandom, 0);

    op(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    op(1'b1, 1'b0, 5'd5, 32'h0, 0);
    op(1'b1, 1'b1, 5'd2, 32'h1, 0);
    op(1'b1, 1'b0, 5'd2, 32'h0, 0);

    // Abort a write with reset one edge after acceptance.
    begin : reset_abort
      int acc;
      while (cyc + 1 < next_free) step();
      bus.write_en   = 1'b1;
      bus.addr0      = 5'd3;
      bus.write_data = 32'h55;
      acc = cyc + 1;
      step();
      rst          = 1'b1;
      bus.write_en = 1'b0;
      step();
      chk(cyc == acc + 1, "reset_edge", cyc, acc + 1);
      chk(bus.write_done == 1'b0, "abort_write_done", {31'b0, bus.write_done}, 32'h0);
      chk(bus.read_data == '0, "abort_read_data", bus.read_data, 32'h0);
      rst = 1'b0;
      next_free = cyc + 1;
    end
    op(1'b1, 1'b0, 5'd3, 32'h0, 0);

    op(1'b1, 1'b0, 5'd20, 32'h0, 0);
    op(1'b0, 1'b1, 5'd20, 32'hAAAA5555, 0);
    op(1'b1, 1'b0, 5'd4, 32'h0, 0);
    op(1'b1, 1'b0, 5'd20, 32'h0, 0);

    op(1'b1, 1'b0, 5'd7, 32'h0, 1);
    op(1'b1, 1'b0, 5'd9, 32'h0, 2);
    op(1'b0, 1'b1, 5'd11, $urandom, 2);
    op(1'b0, 1'b1, 5'd12, $urandom, 1);

    for (int n = 0; n < 200; n++) begin
      int kind;
      int mode;
      kind = $urandom_range(0, 2);
      mode = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) step();
      op(kind != 1, kind != 0, IDX_SIZE'($urandom_range(0, 23)), $urandom, mode);
    end

    for (int w = 0; w < 20 && sb.size() != 0; w++) step();
    repeat (3) step();
    chk(sb.size() == 0, "drain", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dyn_latency_mem_d1.md
DYN_LATENCY_MEM_D1 -- requirements
Module: dyn_latency_mem_d1

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter SIZE, default 16: number of words.
REQ-003 Parameter IDX_SIZE, default 4: address width in bits.
REQ-004 Parameter LATENCY, default 3: the block SHALL reject any value below 1 at elaboration.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 addr0  input  IDX_SIZE  request address.
REQ-008 read_en  input  1  level read request, held until read_done is seen.
REQ-009 write_en  input  1  level write request, held until write_done is seen.
REQ-010 write_data  input  WIDTH  write data.
REQ-011 read_data  output  WIDTH  registered read result.
REQ-012 read_done  output  1  one-cycle read completion pulse.
REQ-013 write_done  output  1  one-cycle write completion pulse.
REQ-014 addr_err  output  1  one-cycle out-of-range pulse; this port SHALL exist only when DYN_MEM_ADDR_CHECK_EN is defined.

Function
REQ-015 The block SHALL implement a 4-state FSM: IDLE, BUSY_RD, BUSY_WR, DONE.
REQ-016 IDLE with read_en=1: latch addr0, load the counter with LATENCY-1, go to BUSY_RD; read SHALL win if read_en and write_en are both 1.
REQ-017 IDLE with write_en=1 and read_en=0: latch addr0 and write_data, load the counter with LATENCY-1, go to BUSY_WR.
REQ-018 BUSY_* with counter!=0: decrement the counter; inputs are ignored.
REQ-019 BUSY_RD with counter==0: read_data <= mem[latched addr], read_done <= 1, go to DONE.
REQ-020 BUSY_WR with counter==0: mem[latched addr] <= latched data, write_done <= 1, go to DONE.
REQ-021 DONE: clear both done outputs, go to IDLE; read_en and write_en SHALL be ignored in DONE, covering the cycle in which the requester deasserts them.
REQ-022 Latency: for a request accepted at edge A, done SHALL rise at edge A+LATENCY and fall at edge A+LATENCY+1.
REQ-023 Back-to-back: a new request SHALL be accepted no earlier than edge A+LATENCY+2.
REQ-024 Once a request is accepted it SHALL complete, even if read_en or write_en drops mid-operation.
REQ-025 Changes to addr0 or write_data after acceptance SHALL have no effect on the operation in progress.
REQ-026 read_data SHALL hold its value until the next read completion; a write SHALL NOT alter read_data.
REQ-027 Out-of-range address (>= SIZE): a write SHALL be dropped, a read SHALL return 0, and done SHALL still pulse with normal latency.
REQ-028 Read-after-write to the same address SHALL return the new data.

Reset
REQ-029 Reset SHALL force IDLE, counter=0, read_data=0, read_done=0, write_done=0 and addr_err=0.
REQ-030 Reset SHALL leave memory contents unchanged.
REQ-031 Reset asserted in BUSY_* SHALL abort the operation: no memory update and no done pulse.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-033 DYN_MEM_ADDR_CHECK_EN defined: the addr_err port SHALL exist and SHALL pulse together with read_done or write_done for an out-of-range access.
REQ-034 DYN_MEM_ADDR_CHECK_EN undefined: the addr_err port and its logic SHALL be absent; the out-of-range behaviour of REQ-027 still applies.

Structure
REQ-035 Package dyn_mem_pkg SHALL hold the FSM state enum typedef (2-bit) and the state encoding constants.
REQ-036 The latency down-counter SHALL be the sub-module dyn_mem_lat_counter, with inputs load and dec and output zero, sized $clog2(LATENCY+1).
REQ-037 Memory SHALL be a flat unpacked array of SIZE words, with no byte enables.

Verification
REQ-038 (Parameters LATENCY=3, WIDTH=32, SIZE=16.) Write 0xDEADBEEF to address 5, accepted at edge A -> write_done=1 only in the cycle after edge A+3.
REQ-039 Read address 5 after REQ-038 -> read_data=0xDEADBEEF with read_done pulsing at edge A'+3; read_data is held afterward.
REQ-040 read_en=1 and write_en=1 in IDLE, with write_data=0x1 at address 2 -> read performed first; address 2 is unchanged until the write is re-presented.
REQ-041 Reset asserted at edge A+1 of a write of 0x55 to address 3 -> no write_done, mem[3] unchanged, FSM in IDLE the next cycle.
REQ-042 Read address 20 with the macro defined -> read_data=0 and read_done and addr_err pulse together at A+3; write to address 20 -> the array is unchanged.
REQ-043 Requester drops read_en one cycle after acceptance -> read_done still pulses at A+3; a request held high through DONE is not re-accepted until IDLE.
